id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register directly downstream of the decode control unit.
- Captures the decoded control bundle, operands, immediate, PC and register addresses each cycle.
- Inserts bubbles on load-use hazards and branch flushes.
- Holds an FPU-dispatched instruction in EX through a req/ack/done handshake with the FPU, stalling fetch and decode meanwhile.

Parameters:
- XLEN, 32, data/PC width
- REG_ADDR_W, 5, register address width
- CTRL_W, 20, width of the opaque control bundle (alu_control, result_src, write_src, branch, jump, etc.)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ctrl_d  in  CTRL_W  opaque decoded control fields
- mem_read_d, reg_write_d, fpu_reg_write_d, fpu_dispatch_d  in  1 each  decoded control bits this block inspects
- pc_d, rd1_d, rd2_d, imm_d  in  XLEN each  decode-stage values
- rs1_d, rs2_d, rd_d  in  REG_ADDR_W each  decode register addresses
- valid_d  in  1  decode holds a real instruction
- flush_e  in  1  taken branch/jump resolved in EX; squash the instruction entering EX
- fpu_ack  in  1  FPU accepted request
- fpu_done  in  1  FPU finished; result available
- ctrl_e  out  CTRL_W  registered control bundle
- mem_read_e, reg_write_e, fpu_reg_write_e, fpu_dispatch_e  out  1 each  registered bits
- pc_e, rd1_e, rd2_e, imm_e  out  XLEN each  registered values
- rs1_e, rs2_e, rd_e  out  REG_ADDR_W each  registered addresses
- valid_e  out  1  EX holds a real instruction
- fpu_req  out  1  FPU request, held until ack
- stall_f, stall_d  out  1 each  hold PC / hold IF-ID register

Behaviour:
- Reset: all EX registers 0, valid_e=0, FSM=IDLE, fpu_req=0. Reset mid-FPU-transaction drops to IDLE with no request.
- Bubble: valid_e=0 and every control output 0 (ctrl_e=0, reg_write_e=0, mem_read_e=0, fpu_*_e=0). Data/address registers are don't-care but must be zeroed.
- Load-use hazard (combinational): lu = valid_e & mem_read_e & rd_e matches rs1_d or rs2_d & (rd_e!=0 | fpu_reg_write_e) & valid_d.
- fpu_hold (combinational) = FSM != IDLE, or (FSM==IDLE & valid_e & fpu_dispatch_e).
- FSM transitions:
  - IDLE -> REQ when valid_e & fpu_dispatch_e.
  - REQ (fpu_req=1): on fpu_ack&fpu_done -> DONE; on fpu_ack -> BUSY.
  - BUSY: on fpu_done -> DONE.
  - DONE: one cycle, EX register releases, -> IDLE.
- DONE guarantees that a back-to-back FPU instruction entering EX re-triggers REQ on the next cycle.
- fpu_req is a registered output, 1 exactly in REQ.
- Stall outputs: stall_f = stall_d = lu | (fpu_hold & FSM!=DONE).
- EX register update priority, highest first:
  - fpu_hold & FSM!=DONE: hold everything; flush_e ignored, since the FPU op is older.
  - flush_e: load bubble.
  - lu: load bubble (decode held by stall_d).
  - !valid_d: load bubble.
  - Otherwise: capture all *_d inputs, valid_e=1.
- Latency: 1 cycle decode->EX when unstalled. An FPU op occupies EX for ack latency + done latency + 2 cycles minimum (REQ, DONE).
- fpu_ack/fpu_done outside REQ/BUSY are ignored.

Test Plan:
- Reset then valid_d=1, pc_d=0x100, imm_d=0x10, reg_write_d=1 -> next cycle valid_e=1, pc_e=0x100, imm_e=0x10, reg_write_e=1; stalls 0.
- EX load with mem_read_e=1, rd_e=5; decode rs2_d=5 -> stall_f=stall_d=1 for 1 cycle, bubble in EX, then the dependent instruction enters EX. Repeat with rd_e=0, fpu_reg_write_e=0 -> no stall.
- fpu_dispatch_d=1 enters EX; ack at cycle+2, done at cycle+5 -> fpu_req=1 only in REQ cycles, stalls held until the DONE cycle, EX contents unchanged throughout, next instruction enters EX the cycle after DONE.
- flush_e=1 with valid_d=1, reg_write_d=1 -> next cycle valid_e=0, reg_write_e=0, ctrl_e=0.
- flush_e=1 while FSM=BUSY -> EX contents retained, FSM unaffected.
- rst=1 asserted in BUSY -> next cycle FSM=IDLE, fpu_req=0, valid_e=0, stall_f=stall_d=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubbling, branch flush,
// and an FPU req/ack/done handshake that holds the instruction in EX.
module id_ex_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CTRL_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_W-1:0]     ctrl_d,
    input  logic                  mem_read_d,
    input  logic                  reg_write_d,
    input  logic                  fpu_reg_write_d,
    input  logic                  fpu_dispatch_d,
    input  logic [XLEN-1:0]       pc_d,
    input  logic [XLEN-1:0]       rd1_d,
    input  logic [XLEN-1:0]       rd2_d,
    input  logic [XLEN-1:0]       imm_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  valid_d,
    input  logic                  flush_e,
    input  logic                  fpu_ack,
    input  logic                  fpu_done,
    output logic [CTRL_W-1:0]     ctrl_e,
    output logic                  mem_read_e,
    output logic                  reg_write_e,
    output logic                  fpu_reg_write_e,
    output logic                  fpu_dispatch_e,
    output logic [XLEN-1:0]       pc_e,
    output logic [XLEN-1:0]       rd1_e,
    output logic [XLEN-1:0]       rd2_e,
    output logic [XLEN-1:0]       imm_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  valid_e,
    output logic                  fpu_req,
    output logic                  stall_f,
    output logic                  stall_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } fpu_state_t;

    fpu_state_t state;
    logic       lu;
    logic       fpu_hold;
    logic       ex_hold;
    logic       bubble;

    // Hazard detection; register x0 only counts when the load targets the FP file.
    always_comb begin
        lu = valid_e & mem_read_e & valid_d
           & ((rd_e == rs1_d) | (rd_e == rs2_d))
           & ((rd_e != '0) | fpu_reg_write_e);
        fpu_hold = (state != IDLE) | (valid_e & fpu_dispatch_e);
        ex_hold  = fpu_hold & (state != DONE);
        bubble   = flush_e | lu | ~valid_d;
        stall_f  = lu | ex_hold;
        stall_d  = lu | ex_hold;
    end

    // FPU handshake; fpu_req is high exactly while in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fpu_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_e & fpu_dispatch_e) begin
                        state   <= REQ;
                        fpu_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (fpu_ack) begin
                        state   <= fpu_done ? DONE : BUSY;
                        fpu_req <= 1'b0;
                    end
                end
                BUSY: begin
                    if (fpu_done) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    fpu_req <= 1'b0;
                end
            endcase
        end
    end

    // EX register: an in-flight FPU op outranks flush since it is older.
    always_ff @(posedge clk) begin
        if (rst || (!ex_hold && bubble)) begin
            ctrl_e          <= '0;
            mem_read_e      <= 1'b0;
            reg_write_e     <= 1'b0;
            fpu_reg_write_e <= 1'b0;
            fpu_dispatch_e  <= 1'b0;
            pc_e            <= '0;
            rd1_e           <= '0;
            rd2_e           <= '0;
            imm_e           <= '0;
            rs1_e           <= '0;
            rs2_e           <= '0;
            rd_e            <= '0;
            valid_e         <= 1'b0;
        end else if (!ex_hold) begin
            ctrl_e          <= ctrl_d;
            mem_read_e      <= mem_read_d;
            reg_write_e     <= reg_write_d;
            fpu_reg_write_e <= fpu_reg_write_d;
            fpu_dispatch_e  <= fpu_dispatch_d;
            pc_e            <= pc_d;
            rd1_e           <= rd1_d;
            rd2_e           <= rd2_d;
            imm_e           <= imm_d;
            rs1_e           <= rs1_d;
            rs2_e           <= rs2_d;
            rd_e            <= rd_d;
            valid_e         <= 1'b1;
        end
    end

endmodule
